// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged FIFO: read-mode constants and count sizing.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Occupancy needs one bit more than the pointers to represent a full FIFO.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer with enable; wraps by explicit compare so any depth works.
module fifo_ptr #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    output logic [ADDR_WIDTH-1:0] ptr_o
);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) ptr_d = '0;
            else                                 ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with selectable read mode, occupancy count, threshold flags
// and sticky overflow/underflow errors.
module fifo_flagged
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 1 << ADDR_WIDTH,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enq,
    input  logic                                deq,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                clr_err,
    output logic [DATA_WIDTH-1:0]               data_out,
    output logic                                empty,
    output logic                                full,
    output logic                                almost_empty,
    output logic                                almost_full,
    output logic [count_width(ADDR_WIDTH)-1:0]  count,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int CW = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("fifo_flagged: FIFO_DEPTH must be within 2..2**ADDR_WIDTH");
    end
    if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
        $error("fifo_flagged: AF_THRESH must be within 1..FIFO_DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("fifo_flagged: AE_THRESH must be within 0..FIFO_DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("fifo_flagged: FWFT must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          ae_q, ae_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          deq_ok, enq_ok;

    // A pop frees a slot in the same edge, so a full FIFO can still take a push.
    assign deq_ok = deq & ~empty_q;
    assign enq_ok = enq & (~full_q | deq_ok);

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (enq_ok),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (deq_ok),
        .ptr_o (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (enq_ok) mem[wr_ptr] <= data_in;
    end

    // Flags come from the next count so they never lag the count register.
    always_comb begin
        count_d = count_q;
        if (enq_ok && !deq_ok)      count_d = count_q + CW'(1);
        else if (deq_ok && !enq_ok) count_d = count_q - CW'(1);
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        ae_d    = (count_d <= AE_C);
        af_d    = (count_d >= AF_C);
        ovf_d   = (enq & ~enq_ok) | (ovf_q & ~clr_err);
        unf_d   = (deq & empty_q) | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign data_out = empty_q ? '0 : mem[rd_ptr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)      dout_q <= '0;
            else if (deq_ok) dout_q <= mem[rd_ptr];
        end
        assign data_out = dout_q;
    end

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged: depth-16 registered, depth-5 registered and
// depth-4 first-word-fall-through instances driven by scenario tasks.
module tb_fifo_flagged;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // depth 16, registered output
    logic        s_enq, s_deq, s_clr;
    logic [63:0] s_din, s_dout;
    logic        s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic [4:0]  s_count;

    // depth 5, registered output
    logic        d_enq, d_deq, d_clr;
    logic [7:0]  d_din, d_dout;
    logic        d_empty, d_full, d_ae, d_af, d_ovf, d_unf;
    logic [3:0]  d_count;

    // depth 4, first-word-fall-through
    logic        f_enq, f_deq, f_clr;
    logic [7:0]  f_din, f_dout;
    logic        f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic [2:0]  f_count;

    fifo_flagged #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .FIFO_DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .reset(rst_n), .enq(s_enq), .deq(s_deq), .data_in(s_din),
        .clr_err(s_clr), .data_out(s_dout), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_flagged #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FIFO_DEPTH(5), .FWFT(0)) u_d5 (
        .clk(clk), .reset(rst_n), .enq(d_enq), .deq(d_deq), .data_in(d_din),
        .clr_err(d_clr), .data_out(d_dout), .empty(d_empty), .full(d_full),
        .almost_empty(d_ae), .almost_full(d_af), .count(d_count),
        .overflow(d_ovf), .underflow(d_unf)
    );

    fifo_flagged #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FIFO_DEPTH(4), .FWFT(1)) u_fw (
        .clk(clk), .reset(rst_n), .enq(f_enq), .deq(f_deq), .data_in(f_din),
        .clr_err(f_clr), .data_out(f_dout), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        s_enq = 0; s_deq = 0; s_clr = 0; s_din = '0;
        d_enq = 0; d_deq = 0; d_clr = 0; d_din = '0;
        f_enq = 0; f_deq = 0; f_clr = 0; f_din = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_unf} !== {5'd0, 6'b101000}) begin
            errors++;
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b exp cnt=0 e=1 f=0 ae=1 af=0 ov=0 un=0",
                     s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_unf);
        end
        checks++;
        if (s_dout !== 64'd0) begin
            errors++; $display("FAIL reset_dout: got %h exp 0", s_dout);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            s_enq = 1; s_din = 64'(i);
            tick();
            checks++;
            if (s_count !== 5'(i + 1)) begin
                errors++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, s_count, i + 1);
            end
            checks++;
            if (s_af !== (i + 1 >= 14)) begin
                errors++; $display("FAIL fill_af[%0d]: got %b exp %b", i, s_af, (i + 1 >= 14));
            end
            checks++;
            if (s_full !== (i == 15)) begin
                errors++; $display("FAIL fill_full[%0d]: got %b exp %b", i, s_full, (i == 15));
            end
            checks++;
            if (s_ae !== (i + 1 <= 2)) begin
                errors++; $display("FAIL fill_ae[%0d]: got %b exp %b", i, s_ae, (i + 1 <= 2));
            end
        end
        s_din = 64'hDEAD;
        tick();
        s_enq = 0;
        checks++;
        if ({s_ovf, s_count, s_full} !== {1'b1, 5'd16, 1'b1}) begin
            errors++; $display("FAIL overflow: got ov=%b cnt=%0d f=%b exp ov=1 cnt=16 f=1", s_ovf, s_count, s_full);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 16; i++) begin
            s_deq = 1;
            tick();
            checks++;
            if (s_dout !== 64'(i)) begin
                errors++; $display("FAIL drain_data[%0d]: got %h exp %h", i, s_dout, 64'(i));
            end
            checks++;
            if (s_count !== 5'(15 - i) || s_empty !== (i == 15)) begin
                errors++; $display("FAIL drain_count[%0d]: got cnt=%0d e=%b exp cnt=%0d e=%b", i, s_count, s_empty, 15 - i, (i == 15));
            end
        end
        tick();
        s_deq = 0;
        checks++;
        if ({s_unf, s_count, s_empty} !== {1'b1, 5'd0, 1'b1}) begin
            errors++; $display("FAIL underflow: got un=%b cnt=%0d e=%b exp un=1 cnt=0 e=1", s_unf, s_count, s_empty);
        end
        checks++;
        if (s_dout !== 64'd15) begin
            errors++; $display("FAIL hold_dout_empty: got %h exp f", s_dout);
        end
        s_clr = 1;
        tick();
        s_clr = 0;
        checks++;
        if ({s_ovf, s_unf} !== 2'b00) begin
            errors++; $display("FAIL clr_both: got ov=%b un=%b exp 0 0", s_ovf, s_unf);
        end
    endtask

    task automatic test_wrap_depth5();
        int cnt;
        do_reset();
        cnt = 0;
        for (int c = 0; c < 17; c++) begin
            d_enq = (c < 12);
            d_deq = (c >= 5);
            d_din = 8'(c);
            tick();
            cnt = cnt + (c < 12 ? 1 : 0) - (c >= 5 ? 1 : 0);
            checks++;
            if (d_count !== 4'(cnt) || d_count > 4'd5) begin
                errors++; $display("FAIL wrap_count[%0d]: got %0d exp %0d", c, d_count, cnt);
            end
            checks++;
            if (d_af !== (cnt >= 3) || d_ae !== (cnt <= 2) || d_full !== (cnt == 5)) begin
                errors++; $display("FAIL wrap_flags[%0d]: got af=%b ae=%b f=%b exp af=%b ae=%b f=%b",
                                   c, d_af, d_ae, d_full, (cnt >= 3), (cnt <= 2), (cnt == 5));
            end
            if (c >= 5) begin
                checks++;
                if (d_dout !== 8'(c - 5)) begin
                    errors++; $display("FAIL wrap_data[%0d]: got %h exp %h", c, d_dout, 8'(c - 5));
                end
            end
        end
        d_enq = 0; d_deq = 0;
        checks++;
        if ({d_empty, d_ovf, d_unf} !== 3'b100) begin
            errors++; $display("FAIL wrap_end: got e=%b ov=%b un=%b exp e=1 ov=0 un=0", d_empty, d_ovf, d_unf);
        end
    endtask

    task automatic test_fwft();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'hB1; exp_seq[1] = 8'hB2; exp_seq[2] = 8'hC0;
        do_reset();
        f_enq = 1; f_din = 8'hAB;
        tick();
        f_enq = 0;
        checks++;
        if ({f_dout, f_empty, f_count} !== {8'hAB, 1'b0, 3'd1}) begin
            errors++; $display("FAIL fwft_first: got d=%h e=%b cnt=%0d exp d=ab e=0 cnt=1", f_dout, f_empty, f_count);
        end
        for (int i = 0; i < 3; i++) begin
            f_enq = 1; f_din = 8'hB0 + 8'(i);
            tick();
        end
        f_enq = 0;
        checks++;
        if ({f_dout, f_full, f_count} !== {8'hAB, 1'b1, 3'd4}) begin
            errors++; $display("FAIL fwft_full: got d=%h f=%b cnt=%0d exp d=ab f=1 cnt=4", f_dout, f_full, f_count);
        end
        f_enq = 1; f_deq = 1; f_din = 8'hC0;
        tick();
        f_enq = 0;
        checks++;
        if ({f_count, f_full, f_ovf, f_unf, f_dout} !== {3'd4, 1'b1, 1'b0, 1'b0, 8'hB0}) begin
            errors++; $display("FAIL fwft_full_enqdeq: got cnt=%0d f=%b ov=%b un=%b d=%h exp cnt=4 f=1 ov=0 un=0 d=b0",
                               f_count, f_full, f_ovf, f_unf, f_dout);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (f_dout !== exp_seq[i] || f_count !== 3'(3 - i)) begin
                errors++; $display("FAIL fwft_pop[%0d]: got d=%h cnt=%0d exp d=%h cnt=%0d", i, f_dout, f_count, exp_seq[i], 3 - i);
            end
        end
        tick();
        checks++;
        if ({f_empty, f_count} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL fwft_empty: got e=%b cnt=%0d exp e=1 cnt=0", f_empty, f_count);
        end
        f_enq = 1; f_din = 8'h5A;
        tick();
        f_enq = 0; f_deq = 0;
        checks++;
        if ({f_unf, f_count, f_empty, f_dout} !== {1'b1, 3'd1, 1'b0, 8'h5A}) begin
            errors++; $display("FAIL empty_enqdeq: got un=%b cnt=%0d e=%b d=%h exp un=1 cnt=1 e=0 d=5a",
                               f_unf, f_count, f_empty, f_dout);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            s_enq = 1; s_din = 64'h10 + 64'(i);
            tick();
        end
        s_enq = 0; s_deq = 1;
        tick();
        s_deq = 0;
        checks++;
        if ({s_count, s_dout} !== {5'd9, 64'h10}) begin
            errors++; $display("FAIL pre_reset: got cnt=%0d d=%h exp cnt=9 d=10", s_count, s_dout);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_unf} !== {5'd0, 6'b101000} || s_dout !== 64'd0) begin
            errors++; $display("FAIL async_reset: got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b d=%h exp cnt=0 e=1 f=0 ae=1 af=0 ov=0 un=0 d=0",
                               s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_unf, s_dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s_enq = 1; s_din = 64'h1;
        tick();
        s_din = 64'h2;
        tick();
        s_enq = 0;
        checks++;
        if (s_count !== 5'd2) begin
            errors++; $display("FAIL post_reset_count: got %0d exp 2", s_count);
        end
        s_deq = 1;
        tick();
        checks++;
        if (s_dout !== 64'h1) begin
            errors++; $display("FAIL post_reset_rd1: got %h exp 1", s_dout);
        end
        tick();
        s_deq = 0;
        checks++;
        if ({s_dout, s_empty} !== {64'h2, 1'b1}) begin
            errors++; $display("FAIL post_reset_rd2: got d=%h e=%b exp d=2 e=1", s_dout, s_empty);
        end
    endtask

    task automatic test_clr_err_priority();
        do_reset();
        s_enq = 1;
        for (int i = 0; i < 17; i++) begin
            s_din = 64'(i);
            tick();
        end
        checks++;
        if (s_ovf !== 1'b1) begin
            errors++; $display("FAIL prio_setup: got ov=%b exp 1", s_ovf);
        end
        s_clr = 1;
        tick();
        checks++;
        if (s_ovf !== 1'b1) begin
            errors++; $display("FAIL set_beats_clr: got ov=%b exp 1", s_ovf);
        end
        s_enq = 0;
        tick();
        s_clr = 0;
        checks++;
        if ({s_ovf, s_count} !== {1'b0, 5'd16}) begin
            errors++; $display("FAIL clr_alone: got ov=%b cnt=%0d exp ov=0 cnt=16", s_ovf, s_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wrap_depth5();
        test_fwft();
        test_async_reset();
        test_clr_err_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
